// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART constants for the transmit arbiter:
// FSM state encodings and parameter defaults.
package uart_tx_arbiter_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam int DEF_N            = 4;
  localparam int DEF_W            = 32;
  localparam int DEF_BUSY_TIMEOUT = 8;

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit
// at or after (last+1) mod N, wrapping around.
module rr_pick #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] winner,
  output logic          found
);

  logic [LW-1:0] w_idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    found  = |req;
    winner = last;
    w_idx  = '0;
    for (int i = N; i >= 1; i--) begin
      w_idx = LW'((int'(last) + i) % N);
      if (req[w_idx]) winner = w_idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding N requesters into one
// multibyte UART transmitter with a busy-start timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int W            = DEF_W,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   tx_data,
  output logic           tx_req,
  input  logic           tx_ready,
  output logic           busy,
  output logic           timeout_err
);

  localparam int LW = $clog2(N);
  localparam int CW = cnt_width(BUSY_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(BUSY_TIMEOUT);

  logic [1:0]    r_state;
  logic [LW-1:0] r_last;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_ack;
  logic [W-1:0]  r_tx_data;
  logic          r_tx_req;
  logic          r_timeout;

  logic [LW-1:0] w_win;
  logic          w_found;
  logic          w_cnt_hit;

  rr_pick #(
    .N  (N),
    .LW (LW)
  ) u_pick (
    .req    (req),
    .last   (r_last),
    .winner (w_win),
    .found  (w_found)
  );

  assign w_cnt_hit = (int'(r_cnt) + 1) >= BUSY_TIMEOUT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last    <= LW'(N - 1);
      r_cnt     <= '0;
      r_ack     <= '0;
      r_tx_data <= '0;
      r_tx_req  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_ack    <= '0;
      r_tx_req <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (tx_ready && w_found) begin
            r_tx_data <= req_data[int'(w_win)*W +: W];
            r_ack     <= N'(1) << w_win;
            r_last    <= w_win;
            r_state   <= ST_ISSUE;
          end
        end
        // Start pulse is registered, so it lands one
        // cycle after the load/ack.
        ST_ISSUE: begin
          r_tx_req <= 1'b1;
          r_cnt    <= '0;
          r_state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!tx_ready) begin
            r_state <= ST_WAIT_DONE;
          end else if (w_cnt_hit) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack         = r_ack;
  assign tx_data     = r_tx_data;
  assign tx_req      = r_tx_req;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple
// transmitter model for the back-to-back scenarios.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int BT = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [W-1:0]   tx_data;
  logic           tx_req;
  logic           tx_ready;
  logic           busy;
  logic           timeout_err;

  logic tb_ready;
  logic model_ready;
  bit   model_en;
  int   busy_len;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  assign tx_ready = model_en ? model_ready : tb_ready;

  always #50 clk = ~clk;

  uart_tx_arbiter #(
    .N            (N),
    .W            (W),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Transmitter model: goes busy for busy_len cycles after a start pulse.
  initial begin
    model_ready = 1'b1;
    forever begin
      @(posedge clk);
      if (model_en && tx_req) begin
        #1 model_ready = 1'b0;
        repeat (busy_len) @(posedge clk);
        #1 model_ready = 1'b1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    tb_ready = 1'b1;
    model_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_ack(output logic [N-1:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ack != '0) begin
        a  = ack;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    req      = '1;
    req_data = '1;
    tb_ready = 1'b1;
    model_en = 1'b0;
    tick();
    tick();
    checks++;
    if (ack !== '0) begin
      failures++;
      $display("FAIL reset_ack got=%b exp=0000", ack);
    end
    checks++;
    if (tx_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_tx_req got=%b exp=0", tx_req);
    end
    checks++;
    if (tx_data !== '0) begin
      failures++;
      $display("FAIL reset_tx_data got=%h exp=0", tx_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_timeout_err got=%b exp=0", timeout_err);
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    req_data[0*W +: W] = 32'hDEADBEEF;
    req = 4'b0001;
    tick();
    checks++;
    if (ack !== 4'b0001 || tx_req !== 1'b0) begin
      failures++;
      $display("FAIL single_ack got=%b/%b exp=0001/0", ack, tx_req);
    end
    req = '0;
    tick();
    checks++;
    if (tx_req !== 1'b1 || ack !== '0) begin
      failures++;
      $display("FAIL single_tx_req got=%b/%b exp=1/0000", tx_req, ack);
    end
    checks++;
    if (tx_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_tx_data got=%h exp=deadbeef", tx_data);
    end
    tb_ready = 1'b0;
    tick();
    tick();
    tick();
    tb_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || tx_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_done got busy=%b data=%h exp busy=0 data=deadbeef",
               busy, tx_data);
    end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int got [5]       = '{-1, -1, -1, -1, -1};
    int t_req [2]     = '{0, 0};
    int ng = 0;
    int nr = 0;
    int idx;
    bit ok;
    do_reset();
    busy_len = 20;
    model_en = 1'b1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hC0DE_0000 + i;
    req = '1;
    for (int c = 0; c < 600 && ng < 5; c++) begin
      tick();
      if (tx_req && nr < 2) begin
        t_req[nr] = cyc;
        nr++;
      end
      if (ack != '0) begin
        idx = -1;
        for (int b = 0; b < N; b++) if (ack[b]) idx = b;
        got[ng] = idx;
        checks++;
        if (!$onehot(ack) || tx_data !== 32'hC0DE_0000 + idx) begin
          failures++;
          $display("FAIL b2b_pair got ack=%b data=%h exp onehot data=%h",
                   ack, tx_data, 32'hC0DE_0000 + idx);
        end
        ng++;
      end
    end
    checks++;
    if (ng != 5) begin
      failures++;
      $display("FAIL b2b_grant_count got=%0d exp=5", ng);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got[k] != exp_order[k]) begin
        failures++;
        $display("FAIL b2b_order[%0d] got=%0d exp=%0d", k, got[k], exp_order[k]);
      end
    end
    checks++;
    if (nr < 2 || (t_req[1] - t_req[0]) != 24) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d exp=24", t_req[1] - t_req[0]);
    end
    req = '0;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b2b_idle got=busy exp=idle");
    end
    model_en = 1'b0;
  endtask

  task automatic test_rr_wrap();
    logic [N-1:0] a;
    bit ok;
    do_reset();
    busy_len = 3;
    model_en = 1'b1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h7700_0000 + i;
    req = 4'b0100;
    wait_ack(a, ok);
    checks++;
    if (!ok || a !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_setup got=%b exp=0100", a);
    end
    req = '0;
    wait_idle(ok);
    req = 4'b0101;
    wait_ack(a, ok);
    checks++;
    if (!ok || a !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_first got=%b exp=0001", a);
    end
    wait_ack(a, ok);
    checks++;
    if (!ok || a !== 4'b0100 || tx_data !== 32'h7700_0002) begin
      failures++;
      $display("FAIL wrap_second got=%b/%h exp=0100/77000002", a, tx_data);
    end
    req = '0;
    wait_idle(ok);
    model_en = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    do_reset();
    req_data[1*W +: W] = 32'h1111_2222;
    req = 4'b0010;
    tick();
    checks++;
    if (ack !== 4'b0010) begin
      failures++;
      $display("FAIL to_ack got=%b exp=0010", ack);
    end
    req = '0;
    tick();
    checks++;
    if (tx_req !== 1'b1 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL to_start got=%b/%b exp=1/0", tx_req, timeout_err);
    end
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      n++;
      if (!busy) break;
    end
    checks++;
    if (n != BT || busy !== 1'b0) begin
      failures++;
      $display("FAIL to_cycles got=%0d exp=%0d", n, BT);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_flag got=%b exp=1", timeout_err);
    end
    req_data[0*W +: W] = 32'h0BAD_F00D;
    req = 4'b0001;
    tick();
    checks++;
    if (ack !== 4'b0001 || tx_data !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL to_next got=%b/%h exp=0001/0badf00d", ack, tx_data);
    end
    req = '0;
    tick();
    tb_ready = 1'b0;
    tick();
    tb_ready = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky got=%b exp=1", timeout_err);
    end
    do_reset();
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL to_clear got=%b exp=0", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bit ok;
    do_reset();
    req_data[0*W +: W] = 32'hAAAA_0000;
    req_data[1*W +: W] = 32'hBBBB_1111;
    req = 4'b0001;
    tick();
    req = 4'b0010;
    tick();
    tb_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || ack !== '0) begin
      failures++;
      $display("FAIL mid_pending got busy=%b ack=%b exp 1/0000", busy, ack);
    end
    #20 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ack !== '0 || tx_req !== 1'b0 || tx_data !== '0) begin
      failures++;
      $display("FAIL mid_async got busy=%b ack=%b txr=%b data=%h exp all zero",
               busy, ack, tx_req, tx_data);
    end
    tb_ready = 1'b1;
    bad = 0;
    tick();
    if (ack !== '0 || tx_req !== 1'b0) bad++;
    tick();
    if (ack !== '0 || tx_req !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_hold got=%0d exp=0 pulses", bad);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ack !== 4'b0010 || tx_data !== 32'hBBBB_1111) begin
      failures++;
      $display("FAIL mid_regrant got=%b/%h exp=0010/bbbb1111", ack, tx_data);
    end
    req = '0;
    tick();
    tb_ready = 1'b0;
    tick();
    tb_ready = 1'b1;
    wait_idle(ok);
  endtask

  task automatic test_not_ready();
    int n_ack;
    bit ok;
    do_reset();
    tb_ready = 1'b0;
    req_data[0*W +: W] = 32'h5A5A_A5A5;
    req = 4'b0001;
    n_ack = 0;
    repeat (4) begin
      tick();
      if (ack != '0) n_ack++;
    end
    checks++;
    if (n_ack != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nr_hold got acks=%0d busy=%b exp 0/0", n_ack, busy);
    end
    tb_ready = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b0001 || tx_data !== 32'h5A5A_A5A5) begin
      failures++;
      $display("FAIL nr_ack got=%b/%h exp=0001/5a5aa5a5", ack, tx_data);
    end
    req = '0;
    tick();
    checks++;
    if (tx_req !== 1'b1) begin
      failures++;
      $display("FAIL nr_tx_req got=%b exp=1", tx_req);
    end
    tb_ready = 1'b0;
    tick();
    tb_ready = 1'b1;
    wait_idle(ok);
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tb_ready = 1'b1;
    model_en = 1'b0;
    busy_len = 20;
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_wrap();
    test_timeout();
    test_reset_mid();
    test_not_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter W, default 32: message width in bits, equal to the multibyte transmitter data width.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 8: cycles allowed for tx_ready to fall after tx_req.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock (10 MHz); all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req, input, N bits: per-requester level request; the message is pending while the bit is high.
REQ-007 SHALL have port req_data, input, N*W bits: requester i's message in bits [i*W +: W], stable while req[i] is high.
REQ-008 SHALL have port ack, output, N bits: one-cycle pulse on bit i when requester i's message has been captured.
REQ-009 SHALL have port tx_data, output, W bits: registered message driven to the multibyte transmitter.
REQ-010 SHALL have port tx_req, output, 1 bit: one-cycle start pulse to the transmitter.
REQ-011 SHALL have port tx_ready, input, 1 bit: transmitter idle indication; low while it is sending.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 SHALL have port timeout_err, output, 1 bit: sticky flag, set on busy timeout, cleared only by rst.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-015 IDLE: if tx_ready=1 and req is non-zero, the block SHALL pick winner w by round-robin, load tx_data<=req_data[w], pulse ack[w] in the same cycle as the load, and go to ISSUE.
REQ-016 Round-robin search SHALL start at index (last+1) mod N and wrap around, where last is the previous winner; after reset, last=N-1, so requester 0 has first priority.
REQ-017 ISSUE: tx_req SHALL be 1 for exactly this one cycle; next state is WAIT_BUSY.
REQ-018 WAIT_BUSY: when tx_ready=0, go to WAIT_DONE; if tx_ready stays 1 for BUSY_TIMEOUT cycles, set timeout_err and go to IDLE.
REQ-019 WAIT_DONE: when tx_ready=1, go to IDLE; there is no timeout in this state.
REQ-020 Arbitration SHALL occur only in IDLE; requests that arrive in any other state stay pending and no ack is issued.
REQ-021 A req bit still high in the cycle after its ack SHALL count as a new message.
REQ-022 The latency from req rising (while idle, tx_ready=1) to ack SHALL be 1 cycle, and from req rising to tx_req SHALL be 2 cycles.
REQ-023 The minimum spacing between back-to-back tx_req pulses SHALL be 4 cycles plus the transmitter busy time.
REQ-024 The block SHALL not arbitrate while tx_ready=0, even in IDLE.
REQ-025 tx_data SHALL hold its value from load until the next load.
REQ-026 The timeout counter SHALL be clog2(BUSY_TIMEOUT+1) bits wide, cleared on entry to WAIT_BUSY, and shall saturate rather than wrap.

Reset
REQ-027 rst SHALL asynchronously force the FSM to IDLE, last=N-1, the timeout counter to 0 and timeout_err=0.
REQ-028 While rst is high, outputs SHALL be ack=0, tx_req=0, tx_data=0 and busy=0.
REQ-029 Reset asserted mid-transfer SHALL abandon the message with no further ack or tx_req; the message is not retried.

Structure
REQ-030 The FSM state encodings and the default BUSY_TIMEOUT SHALL live in the shared UART constants include file.
REQ-031 The round-robin pick SHALL be a separate combinational sub-module, rr_pick (inputs: req, last; outputs: winner index, found).
REQ-032 The RTL SHALL be 120-400 lines and shall contain no latches.

Verification
REQ-033 Single request: req=4'b0001, data0=32'hDEADBEEF, tx_ready=1 -> ack=0001 at +1, tx_req at +2, tx_data=32'hDEADBEEF.
REQ-034 Simultaneous requests: req=4'b1111 held, with a modelled transmitter busy for 20 cycles -> grants in order 0,1,2,3,0, with each ack paired with its own data.
REQ-035 Round-robin wrap: last=2, req=4'b0101 -> winner 0, then winner 2 on the next arbitration.
REQ-036 Timeout: tx_ready held at 1 after tx_req -> return to IDLE after 8 cycles, timeout_err=1, next request still served.
REQ-037 Reset mid-send: rst asserted in WAIT_DONE with req=4'b0010 pending -> busy=0 and outputs zero immediately; after release, requester 1 is granted first only if requester 0 is idle.
REQ-038 Not ready: tx_ready=0 in IDLE with req=4'b0001 -> no ack until tx_ready rises, then ack the following cycle.
